// File: rtl/mul_dispatch.sv
// Operand-pair sequencer for the repeated-addition multiplier: FIFO buffering, one multiply
// in flight, dot-product accumulation closed by LAST. Optional timeout: MUL_DISPATCH_TIMEOUT_EN.
module mul_dispatch #(
    parameter int DEPTH   = 4,
    parameter int ACC_W   = 16,
    parameter int TIMEOUT = 600
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [7:0]       IN_A,
    input  logic [7:0]       IN_B,
    input  logic             IN_LAST,
    output logic             MUL_G,
    output logic [7:0]       MUL_A,
    output logic [7:0]       MUL_B,
    input  logic [7:0]       MUL_P,
    input  logic             MUL_Z,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [ACC_W-1:0] ACC,
    output logic             ERR
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_Z, WAIT_CLR} state_t;
    state_t state;

    logic [7:0]       mem_a    [DEPTH];
    logic [7:0]       mem_b    [DEPTH];
    logic             mem_last [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic             last_r;
    logic [ACC_W-1:0] sum;

    assign IN_READY = (count < CNT_W'(DEPTH));
    assign push     = IN_VALID && IN_READY;
    // A finished result must be taken before the next pair starts.
    assign pop      = (state == IDLE) && (count != '0) && !OUT_VALID;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_a[wr_ptr]    <= IN_A;
            mem_b[wr_ptr]    <= IN_B;
            mem_last[wr_ptr] <= IN_LAST;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

`ifdef MUL_DISPATCH_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0] tmr;
`else
    // No watchdog in this build; the comparison is constant false for any sane TIMEOUT.
    assign ERR = (TIMEOUT < 0);
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            MUL_G     <= 1'b0;
            MUL_A     <= '0;
            MUL_B     <= '0;
            last_r    <= 1'b0;
            sum       <= '0;
            ACC       <= '0;
            OUT_VALID <= 1'b0;
`ifdef MUL_DISPATCH_TIMEOUT_EN
            tmr       <= '0;
            ERR       <= 1'b0;
`endif
        end else begin
            MUL_G <= 1'b0;
            if (OUT_VALID && OUT_READY) OUT_VALID <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        MUL_A  <= mem_a[rd_ptr];
                        MUL_B  <= mem_b[rd_ptr];
                        last_r <= mem_last[rd_ptr];
                        MUL_G  <= 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef MUL_DISPATCH_TIMEOUT_EN
                    tmr   <= '0;
`endif
                    state <= WAIT_Z;
                end
                WAIT_Z: begin
                    if (MUL_Z) begin
                        sum   <= sum + ACC_W'(MUL_P);
                        state <= WAIT_CLR;
                    end
`ifdef MUL_DISPATCH_TIMEOUT_EN
                    // A stalled multiplier drops the pair but still lets LAST close the sum.
                    else if (tmr == TMR_W'(TIMEOUT - 1)) begin
                        ERR   <= 1'b1;
                        state <= WAIT_CLR;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
`endif
                end
                WAIT_CLR: begin
                    if (!MUL_Z) begin
                        if (last_r) begin
                            ACC       <= sum;
                            sum       <= '0;
                            OUT_VALID <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_dispatch.sv
// Bench for mul_dispatch: behavioural multiplier stub, directed cases and a randomized
// dot-product run checked against a queue-based reference.
module tb_mul_dispatch;
    localparam int TMO = 600;

    logic        CLK, RESET;
    logic        IN_VALID, IN_READY, IN_LAST;
    logic [7:0]  IN_A, IN_B;
    logic        MUL_G, MUL_Z;
    logic [7:0]  MUL_A, MUL_B, MUL_P;
    logic        OUT_VALID, OUT_READY, ERR;
    logic [15:0] ACC;

    int checks = 0;
    int errors = 0;
    int g_count = 0;
    bit stuck = 0;

    int run_sum = 0;
    int exp_q[$];

    mul_dispatch dut (
        .CLK(CLK), .RESET(RESET),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_A(IN_A), .IN_B(IN_B), .IN_LAST(IN_LAST),
        .MUL_G(MUL_G), .MUL_A(MUL_A), .MUL_B(MUL_B), .MUL_P(MUL_P), .MUL_Z(MUL_Z),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .ACC(ACC), .ERR(ERR)
    );

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Multiplier stub: takes A+1 cycles, holds Z for 1..3 cycles with P=A*B mod 256.
    initial begin
        bit         busy = 0;
        bit         prev_g = 0;
        logic [7:0] ma = 0, mb = 0;
        int         cnt = 0, zhold = 0;
        MUL_Z = 0;
        MUL_P = 0;
        forever begin
            @(negedge CLK or posedge RESET);
            if (RESET) begin
                busy = 0; prev_g = 0; MUL_Z = 0; MUL_P = 0;
            end else begin
                if (MUL_G) begin
                    g_count++;
                    chk("g_single_cycle", 32'(prev_g), 32'd0);
                    chk("g_while_busy", 32'(busy), 32'd0);
                end
                prev_g = MUL_G;
                if (busy) begin
                    chk("a_stable", 32'(MUL_A), 32'(ma));
                    chk("b_stable", 32'(MUL_B), 32'(mb));
                    cnt--;
                    if (cnt == 0) begin
                        busy  = 0;
                        MUL_Z = 1;
                        MUL_P = 8'((int'(ma) * int'(mb)) % 256);
                        zhold = $urandom_range(1, 3);
                    end
                end else if (MUL_Z) begin
                    zhold--;
                    if (zhold == 0) begin
                        MUL_Z = 0;
                        MUL_P = 8'($urandom);
                    end
                end else if (MUL_G && !stuck) begin
                    busy = 1;
                    ma   = MUL_A;
                    mb   = MUL_B;
                    cnt  = int'(ma) + 1;
                end
            end
        end
    end

    task automatic model_clear();
        run_sum = 0;
        exp_q.delete();
    endtask

    task automatic push(input int a, input int b, input bit last);
        int n = 0;
        @(negedge CLK);
        IN_A = 8'(a); IN_B = 8'(b); IN_LAST = last; IN_VALID = 1;
        while (IN_READY !== 1'b1 && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 5000) begin
            chk("push_timeout", 32'd0, 32'd1);
            IN_VALID = 0;
        end else begin
            @(posedge CLK);
            #1 IN_VALID = 0;
            run_sum = (run_sum + (a * b) % 256) % 65536;
            if (last) begin
                exp_q.push_back(run_sum);
                run_sum = 0;
            end
        end
    endtask

    task automatic wait_out(output logic [15:0] acc, output bit ok);
        int n = 0;
        int hold;
        @(negedge CLK);
        while (OUT_VALID !== 1'b1 && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        ok = (n < 5000);
        acc = 'x;
        if (!ok) begin
            chk("out_timeout", 32'd0, 32'd1);
        end else begin
            acc  = ACC;
            hold = $urandom_range(0, 2);
            repeat (hold) begin
                @(negedge CLK);
                chk("acc_hold", 32'(ACC), 32'(acc));
                chk("valid_hold", 32'(OUT_VALID), 32'd1);
            end
            OUT_READY = 1;
            @(posedge CLK);
            #1 OUT_READY = 0;
            @(negedge CLK);
            chk("valid_clear", 32'(OUT_VALID), 32'd0);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, 32'(IN_READY), 32'd1);
        chk({tag, "_mul_g"}, 32'(MUL_G), 32'd0);
        chk({tag, "_mul_a"}, 32'(MUL_A), 32'd0);
        chk({tag, "_mul_b"}, 32'(MUL_B), 32'd0);
        chk({tag, "_out_valid"}, 32'(OUT_VALID), 32'd0);
        chk({tag, "_acc"}, 32'(ACC), 32'd0);
        chk({tag, "_err"}, 32'(ERR), 32'd0);
    endtask

    initial begin
        logic [15:0] acc;
        bit          ok;
        int          n;
        RESET = 1; IN_VALID = 0; IN_A = 0; IN_B = 0; IN_LAST = 0; OUT_READY = 0;
        repeat (2) @(negedge CLK);
        check_reset_values("reset");
        RESET = 0;

        // (3,4),(5,6,LAST) -> 42 with two issue pulses
        g_count = 0;
        push(3, 4, 0);
        push(5, 6, 1);
        wait_out(acc, ok);
        chk("dot_42", 32'(acc), 32'd42);
        chk("g_pulses_2", 32'(g_count), 32'd2);

        // product wraps mod 256
        push(20, 20, 1);
        wait_out(acc, ok);
        chk("dot_144", 32'(acc), 32'd144);

        // A=0 pair
        push(0, 7, 0);
        push(2, 9, 1);
        wait_out(acc, ok);
        chk("dot_18", 32'(acc), 32'd18);

        // FIFO fills while the multiplier works on a long first pair
        push(200, 1, 0);
        push(3, 3, 0);
        push(7, 2, 0);
        push(1, 9, 0);
        push(2, 2, 1);
        @(negedge CLK);
        chk("fifo_full_ready", 32'(IN_READY), 32'd0);
        wait_out(acc, ok);
        chk("dot_fifo_236", 32'(acc), 32'd236);

        // reset while waiting for Z
        push(4, 4, 0);
        n = 0;
        while (MUL_G !== 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("reset_test_g_seen", 32'(MUL_G), 32'd1);
        repeat (2) @(negedge CLK);
        RESET = 1;
        #1;
        check_reset_values("midreset");
        @(negedge CLK);
        RESET = 0;
        model_clear();
        push(1, 1, 1);
        wait_out(acc, ok);
        chk("dot_after_reset", 32'(acc), 32'd1);

        // randomized dot products against the queue reference
        model_clear();
        fork
            begin
                for (int g = 0; g < 10; g++) begin
                    int len;
                    len = $urandom_range(1, 3);
                    for (int k = 0; k < len; k++) begin
                        int a;
                        a = $urandom_range(0, 30);
                        if ($urandom_range(0, 7) == 0) a = $urandom_range(0, 255);
                        push(a, $urandom_range(0, 255), k == len - 1);
                    end
                end
            end
            begin
                for (int r = 0; r < 10; r++) begin
                    logic [15:0] racc;
                    bit          rok;
                    wait_out(racc, rok);
                    if (rok) begin
                        if (exp_q.size() > 0) chk("rand_dot", 32'(racc), 32'(exp_q.pop_front()));
                        else chk("rand_dot_unexpected", 32'(racc), 32'hFFFF_FFFF);
                    end
                end
            end
        join

`ifdef MUL_DISPATCH_TIMEOUT_EN
        // multiplier never answers: ERR, pair dropped, LAST still closes with 0
        stuck = 1;
        push(5, 5, 1);
        n = 0;
        while (ERR !== 1'b1 && n < TMO + 50) begin
            @(negedge CLK);
            n++;
        end
        chk("timeout_err", 32'(ERR), 32'd1);
        wait_out(acc, ok);
        chk("timeout_acc", 32'(acc), 32'd0);
        stuck = 0;
        push(2, 3, 1);
        wait_out(acc, ok);
        chk("after_timeout_dot", 32'(acc), 32'd6);
        chk("err_sticky", 32'(ERR), 32'd1);
`else
        chk("err_tied_low", 32'(ERR), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
